// File: rtl/dm_store_buffer_if.sv
// -----------------------------------------------------------------------------
// dm_store_buffer_if
//
// Bundles the core data-memory port and the external memory read/write port
// seen by the store buffer.
//
//   Core side
//     in_addr          core load/store address
//     in_wr_data       core store data
//     in_wr_en         core store strobe
//     out_DM_data      load data returned to the core
//   Memory read side
//     out_mem_rd_addr  memory read address (follows in_addr)
//     in_mem_rd_data   memory combinational read data
//   Memory write side (req/ack)
//     out_mem_wr_req   head entry valid
//     out_mem_wr_addr  head entry address (0 when empty)
//     out_mem_wr_data  head entry data (0 when empty)
//     in_mem_wr_ack    memory accepts the head entry this cycle
//   Status
//     out_full / out_empty / out_count / out_overflow
//
// The slave modport is the store buffer; the master modport is whatever
// drives it (core plus memory, or a testbench).
// -----------------------------------------------------------------------------
interface dm_store_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wr_data;
    logic              in_wr_en;
    logic [DATA_W-1:0] out_DM_data;

    logic [ADDR_W-1:0] out_mem_rd_addr;
    logic [DATA_W-1:0] in_mem_rd_data;

    logic              out_mem_wr_req;
    logic [ADDR_W-1:0] out_mem_wr_addr;
    logic [DATA_W-1:0] out_mem_wr_data;
    logic              in_mem_wr_ack;

    logic              out_full;
    logic              out_empty;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;

    modport slave (
        input  in_addr,
        input  in_wr_data,
        input  in_wr_en,
        output out_DM_data,
        output out_mem_rd_addr,
        input  in_mem_rd_data,
        output out_mem_wr_req,
        output out_mem_wr_addr,
        output out_mem_wr_data,
        input  in_mem_wr_ack,
        output out_full,
        output out_empty,
        output out_count,
        output out_overflow
    );

    modport master (
        output in_addr,
        output in_wr_data,
        output in_wr_en,
        input  out_DM_data,
        input  out_mem_rd_addr,
        output in_mem_rd_data,
        input  out_mem_wr_req,
        input  out_mem_wr_addr,
        input  out_mem_wr_data,
        output in_mem_wr_ack,
        input  out_full,
        input  out_empty,
        input  out_count,
        input  out_overflow
    );
endinterface

// File: rtl/dm_store_buffer.sv
// -----------------------------------------------------------------------------
// dm_store_buffer
//
// Store buffer between the RV64IF core data-memory port and external memory.
// Core stores are queued in a DEPTH-entry FIFO and drained in strict order
// over a req/ack handshake so the core never waits on a slow memory. Loads
// are answered combinationally from the youngest queued store to the same
// doubleword, otherwise from the memory read port.
//
// Ports
//   in_Clk   clock, all state updates on the rising edge
//   Rst_N    synchronous active-low reset
//   bus      dm_store_buffer_if.slave (core, memory and status signals)
// -----------------------------------------------------------------------------
module dm_store_buffer #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                 in_Clk,
    input  logic                 Rst_N,
    dm_store_buffer_if.slave     bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Entry storage. Every entry is read in parallel for forwarding, so these
    // stay as plain registers rather than a single-port RAM.
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;

    logic              full;
    logic              empty;
    logic              pop;
    logic              push;

    assign full  = (count_reg == CNT_W'(DEPTH));
    assign empty = (count_reg == '0);

    // Both strobes are masked while reset is asserted so nothing is written
    // or retired during a reset cycle.
    assign pop  = Rst_N && !empty && bus.in_mem_wr_ack;
    assign push = Rst_N && bus.in_wr_en && (!full || pop);

    // -------------------------------------------------------------------------
    // Pointer / count / overflow state
    // -------------------------------------------------------------------------
    always_ff @(posedge in_Clk) begin
        if (!Rst_N) begin
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
            // A strobe that did not become a push was dropped for lack of room.
            if (bus.in_wr_en && !push) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Entry contents need no reset: validity comes from the pointers/count.
    always_ff @(posedge in_Clk) begin
        if (push) begin
            addr_mem[tail_reg] <= bus.in_addr;
            data_mem[tail_reg] <= bus.in_wr_data;
        end
    end

    // -------------------------------------------------------------------------
    // Forwarding: view the FIFO in age order, age 0 = head (oldest).
    // An entry is valid when its age is below count; the head being popped
    // this cycle is still counted, and this cycle's push is not yet stored.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0]  age_match;
    logic [DATA_W-1:0] age_data [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
            logic [PTR_W-1:0] idx;
            logic             valid;
            assign idx   = head_reg + PTR_W'(gi);
            assign valid = (CNT_W'(gi) < count_reg);
            assign age_match[gi] = valid &&
                (addr_mem[idx][ADDR_W-1:3] == bus.in_addr[ADDR_W-1:3]);
            assign age_data[gi]  = data_mem[idx];
        end
    endgenerate

    logic [DATA_W-1:0] fwd_data;

    // Later (younger) matches overwrite earlier ones.
    always_comb begin
        fwd_data = bus.in_mem_rd_data;
        for (int i = 0; i < DEPTH; i++) begin
            if (age_match[i]) begin
                fwd_data = age_data[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.out_DM_data     = fwd_data;
    assign bus.out_mem_rd_addr = bus.in_addr;

    assign bus.out_mem_wr_req  = !empty;
    assign bus.out_mem_wr_addr = empty ? '0 : addr_mem[head_reg];
    assign bus.out_mem_wr_data = empty ? '0 : data_mem[head_reg];

    assign bus.out_full        = full;
    assign bus.out_empty       = empty;
    assign bus.out_count       = count_reg;
    assign bus.out_overflow    = overflow_reg;

endmodule

// File: tb/tb_dm_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_dm_store_buffer
//
// Directed bench for dm_store_buffer (DEPTH=4, 64-bit address and data).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_dm_store_buffer;
    localparam int DEPTH  = 4;
    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic clk;
    logic rst_n;

    int total;
    int bad;

    dm_store_buffer_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_store_buffer #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .in_Clk (clk),
        .Rst_N  (rst_n),
        .bus    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic store(input logic [63:0] a, input logic [63:0] d);
        bus.in_addr    = a;
        bus.in_wr_data = d;
        bus.in_wr_en   = 1'b1;
        cycle();
        bus.in_wr_en   = 1'b0;
    endtask

    initial begin
        int issued;
        int drained;
        logic do_wr;

        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.in_addr        = '0;
        bus.in_wr_data     = '0;
        bus.in_wr_en       = 1'b1;
        bus.in_mem_rd_data = '0;
        bus.in_mem_wr_ack  = 1'b1;

        // ---- reset with strobes active ----
        cycle();
        cycle();
        check("rst_count",   64'(bus.out_count), 64'd0);
        check("rst_empty",   64'(bus.out_empty), 64'd1);
        check("rst_full",    64'(bus.out_full), 64'd0);
        check("rst_req",     64'(bus.out_mem_wr_req), 64'd0);
        check("rst_ovf",     64'(bus.out_overflow), 64'd0);
        check("rst_wr_addr", bus.out_mem_wr_addr, 64'd0);
        check("rst_wr_data", bus.out_mem_wr_data, 64'd0);
        rst_n = 1'b1;
        bus.in_wr_en      = 1'b0;
        bus.in_mem_wr_ack = 1'b0;

        // ---- enqueue and drain ----
        store(64'h100, 64'hA);
        check("enq1_count", 64'(bus.out_count), 64'd1);
        check("enq1_req",   64'(bus.out_mem_wr_req), 64'd1);
        store(64'h108, 64'hB);
        store(64'h200, 64'hC);
        check("enq_count",   64'(bus.out_count), 64'd3);
        check("enq_req",     64'(bus.out_mem_wr_req), 64'd1);
        check("enq_wr_addr", bus.out_mem_wr_addr, 64'h100);
        check("enq_wr_data", bus.out_mem_wr_data, 64'hA);
        cycle();
        check("hold_wr_addr", bus.out_mem_wr_addr, 64'h100);
        bus.in_mem_wr_ack = 1'b1;
        cycle();
        bus.in_mem_wr_ack = 1'b0;
        check("pop_count",   64'(bus.out_count), 64'd2);
        check("pop_wr_addr", bus.out_mem_wr_addr, 64'h108);
        check("pop_wr_data", bus.out_mem_wr_data, 64'hB);

        // ---- forwarding ----
        do_reset();
        store(64'h100, 64'h11);
        store(64'h104, 64'h22);
        bus.in_addr        = 64'h100;
        bus.in_mem_rd_data = 64'hDEAD;
        #1;
        check("fwd_young", bus.out_DM_data, 64'h22);
        bus.in_addr = 64'h300;
        #1;
        check("fwd_miss",    bus.out_DM_data, 64'hDEAD);
        check("fwd_rd_addr", bus.out_mem_rd_addr, 64'h300);
        // store pushed this cycle is not yet visible
        bus.in_wr_data = 64'h33;
        bus.in_wr_en   = 1'b1;
        #1;
        check("fwd_same_cyc", bus.out_DM_data, 64'hDEAD);
        cycle();
        bus.in_wr_en = 1'b0;
        check("fwd_next_cyc", bus.out_DM_data, 64'h33);

        // head being popped still forwards in that cycle
        do_reset();
        store(64'h500, 64'h55);
        bus.in_addr        = 64'h500;
        bus.in_mem_rd_data = 64'h77;
        bus.in_mem_wr_ack  = 1'b1;
        #1;
        check("fwd_popping", bus.out_DM_data, 64'h55);
        cycle();
        bus.in_mem_wr_ack = 1'b0;
        check("fwd_popped", bus.out_DM_data, 64'h77);
        check("ack_low_empty", 64'(bus.out_empty), 64'd1);
        // ack with req low is ignored
        bus.in_mem_wr_ack = 1'b1;
        cycle();
        bus.in_mem_wr_ack = 1'b0;
        check("ack_noreq_count", 64'(bus.out_count), 64'd0);

        // ---- full / overflow ----
        do_reset();
        for (int i = 0; i < 4; i++) store(64'(i * 8), 64'(i + 1));
        check("full_flag",  64'(bus.out_full), 64'd1);
        check("full_count", 64'(bus.out_count), 64'd4);
        store(64'h20, 64'h5);
        check("ovf_flag",    64'(bus.out_overflow), 64'd1);
        check("ovf_count",   64'(bus.out_count), 64'd4);
        check("ovf_wr_addr", bus.out_mem_wr_addr, 64'h0);
        check("ovf_wr_data", bus.out_mem_wr_data, 64'h1);
        // overflow stays sticky after a drain
        bus.in_mem_wr_ack = 1'b1;
        cycle();
        bus.in_mem_wr_ack = 1'b0;
        check("ovf_sticky", 64'(bus.out_overflow), 64'd1);

        // full with simultaneous push and pop
        do_reset();
        check("ovf_cleared", 64'(bus.out_overflow), 64'd0);
        for (int i = 0; i < 4; i++) store(64'(i * 8), 64'(i + 1));
        bus.in_mem_wr_ack = 1'b1;
        store(64'h20, 64'h5);
        check("pp_count", 64'(bus.out_count), 64'd4);
        check("pp_ovf",   64'(bus.out_overflow), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("pp_drain%0d_addr", i), bus.out_mem_wr_addr, 64'(i * 8));
            check($sformatf("pp_drain%0d_data", i), bus.out_mem_wr_data, 64'(i + 1));
            cycle();
        end
        bus.in_mem_wr_ack = 1'b0;
        check("pp_empty", 64'(bus.out_empty), 64'd1);

        // push+pop at count==1
        store(64'h40, 64'h9);
        bus.in_mem_wr_ack = 1'b1;
        store(64'h48, 64'hA);
        bus.in_mem_wr_ack = 1'b0;
        check("pp1_count",   64'(bus.out_count), 64'd1);
        check("pp1_wr_addr", bus.out_mem_wr_addr, 64'h48);

        // ---- wrap-around with random ack gaps ----
        do_reset();
        issued  = 0;
        drained = 0;
        for (int c = 0; c < 300 && drained < 12; c++) begin
            bus.in_mem_wr_ack = ($urandom_range(0, 2) == 0);
            do_wr = (issued < 12) && (!bus.out_full || (bus.in_mem_wr_ack && bus.out_mem_wr_req));
            bus.in_wr_en   = do_wr;
            bus.in_addr    = 64'(issued * 8);
            bus.in_wr_data = 64'h1000 + 64'(issued);
            if (bus.in_mem_wr_ack && bus.out_mem_wr_req) begin
                check($sformatf("wrap%0d_addr", drained), bus.out_mem_wr_addr, 64'(drained * 8));
                check($sformatf("wrap%0d_data", drained), bus.out_mem_wr_data, 64'h1000 + 64'(drained));
                drained++;
            end
            cycle();
            if (do_wr) issued++;
            if (bus.out_count > 3'd4) check("wrap_count_le4", 64'(bus.out_count), 64'd4);
        end
        bus.in_wr_en      = 1'b0;
        bus.in_mem_wr_ack = 1'b0;
        check("wrap_drained", 64'(drained), 64'd12);
        check("wrap_end_count", 64'(bus.out_count), 64'd0);
        check("wrap_ovf", 64'(bus.out_overflow), 64'd0);

        // ---- reset mid-drain ----
        do_reset();
        store(64'h600, 64'h61);
        store(64'h608, 64'h62);
        store(64'h610, 64'h63);
        check("mid_req_before", 64'(bus.out_mem_wr_req), 64'd1);
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        check("mid_req",   64'(bus.out_mem_wr_req), 64'd0);
        check("mid_count", 64'(bus.out_count), 64'd0);
        bus.in_addr        = 64'h600;
        bus.in_mem_rd_data = 64'h77;
        #1;
        check("mid_load", bus.out_DM_data, 64'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
